ms_mul_share_sched: RTL and testbench

- Round-robin scheduler that shares one ms_serial_by2_mul instance among NUM_REQ requesters.
- Per operation it latches the winner's operand vector, clears the multiplier, and holds its enable until the multiplier reports done.
- It then returns the result to the winner over a valid/ack response handshake.
- A watchdog aborts any operation that never completes.
- It sits between the requesting datapath lanes and the core wrapper around the serial multiplier.

---
 rtl/ms_mul_share_sched.sv | 157 +++++++++++++++
 tb/tb_ms_mul_share_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_mul_share_sched.sv
// Round-robin scheduler that time-shares one serial multiplier among NUM_REQ requesters.
// Each job runs grant -> clear -> run (watchdog-bounded) -> response handshake.
module ms_mul_share_sched #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int NUM_REQ    = 3,
    parameter int RES_WIDTH  = DATA_WIDTH * NUM_INPUTS,
    parameter int TIMEOUT    = 2 ** (DATA_WIDTH * NUM_INPUTS) + 8
) (
    input  logic                                      gclk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                        req_ack,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output logic [RES_WIDTH-1:0]                      rsp_data,
    output logic                                      rsp_err,
    input  logic [NUM_REQ-1:0]                        rsp_ack,
    output logic                                      mul_clr,
    output logic                                      mul_en,
    output logic [DATA_WIDTH-1:0]                     mul_data [NUM_INPUTS],
    input  logic [RES_WIDTH-1:0]                      mul_result,
    input  logic                                      mul_done,
    output logic                                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]     NREQ_EXT = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT  = NUM_REQ'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] counter;

    logic [DATA_WIDTH-1:0] slice_ops [NUM_REQ][NUM_INPUTS];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            for (genvar gj = 0; gj < NUM_INPUTS; gj++) begin : g_op
                assign slice_ops[gi][gj] =
                    req_data[(gi*NUM_INPUTS + gj)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    endgenerate

    // Rotate req so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_shift;
    logic [NUM_REQ-1:0]   req_rot;
    logic [PTR_W-1:0]     offset;
    logic [PTR_W:0]       ptr_sum;
    logic [PTR_W-1:0]     winner;
    logic                 found;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> rr_ptr;
    assign req_rot   = req_shift[NUM_REQ-1:0];

    always_comb begin
        found   = |req_rot;
        offset  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = PTR_W'(k);
            end
        end
        ptr_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (ptr_sum >= NREQ_EXT) begin
            ptr_sum = ptr_sum - NREQ_EXT;
        end
        winner  = ptr_sum[PTR_W-1:0];
    end

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            counter   <= '0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mul_clr   <= 1'b0;
            mul_en    <= 1'b0;
            busy      <= 1'b0;
            for (int j = 0; j < NUM_INPUTS; j++) begin
                mul_data[j] <= '0;
            end
        end else begin
            req_ack <= '0;
            mul_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        for (int j = 0; j < NUM_INPUTS; j++) begin
                            mul_data[j] <= slice_ops[winner][j];
                        end
                        owner   <= winner;
                        req_ack <= ONE_HOT << winner;
                        mul_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    counter <= '0;
                    mul_en  <= 1'b1;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_err   <= 1'b0;
                        mul_en    <= 1'b0;
                        rsp_valid <= ONE_HOT << owner;
                        state     <= S_RESP;
                    end else if (counter == CNT_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        mul_en    <= 1'b0;
                        rsp_valid <= ONE_HOT << owner;
                        state     <= S_RESP;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ack[owner]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    mul_en    <= 1'b0;
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_mul_share_sched.sv
// Scoreboard bench for ms_mul_share_sched with a behavioural serial-multiplier model.
module tb_ms_mul_share_sched;

    localparam int DW  = 5;
    localparam int NI  = 2;
    localparam int NR  = 3;
    localparam int RW  = DW * NI;
    localparam int TMO = 2 ** (DW * NI) + 8;

    logic              gclk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*NI*DW-1:0] req_data;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     rsp_valid;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;
    logic [NR-1:0]     rsp_ack;
    logic              mul_clr;
    logic              mul_en;
    logic [DW-1:0]     mul_data [NI];
    logic [RW-1:0]     mul_result;
    logic              mul_done;
    logic              busy;

    ms_mul_share_sched #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR), .RES_WIDTH(RW), .TIMEOUT(TMO)
    ) dut (
        .gclk(gclk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ack(rsp_ack),
        .mul_clr(mul_clr), .mul_en(mul_en), .mul_data(mul_data), .mul_result(mul_result),
        .mul_done(mul_done), .busy(busy)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // Multiplier model: done after model_after enable cycles (0 = never).
    int          model_after;
    logic [15:0] en_cnt;
    always @(posedge gclk or negedge rst) begin
        if (!rst)         en_cnt <= '0;
        else if (mul_clr) en_cnt <= '0;
        else if (mul_en)  en_cnt <= en_cnt + 16'd1;
    end
    assign mul_done   = (model_after != 0) && mul_en && (int'(en_cnt) == model_after - 1);
    assign mul_result = RW'(mul_data[0]) * RW'(mul_data[1]);

    typedef struct {
        int            idx;
        logic [RW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    int            n_checks;
    int            n_fail;
    int            rr_model;
    logic [DW-1:0] ops [NR][NI];
    logic [RW-1:0] last_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        ops[i][0] = DW'(a);
        ops[i][1] = DW'(b);
        req_data[(i*NI+0)*DW +: DW] = DW'(a);
        req_data[(i*NI+1)*DW +: DW] = DW'(b);
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return 0;
    endfunction

    // Waits for a grant, checks it against the round-robin model and queues the expected response.
    task automatic grant(input bit single, output int idx);
        int   n;
        exp_t e;
        n = 0;
        while (req_ack == '0 && n < 50) begin
            @(negedge gclk);
            n++;
        end
        idx = pick(req, rr_model);
        if (n >= 50) begin
            check_eq("grant_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("req_ack", 32'(req_ack), 32'(1 << idx));
            check_eq("mul_clr", 32'(mul_clr), 32'd1);
            check_eq("mul_data0", 32'(mul_data[0]), 32'(ops[idx][0]));
            check_eq("mul_data1", 32'(mul_data[1]), 32'(ops[idx][1]));
            e.idx  = idx;
            e.data = (model_after == 0) ? '0 : RW'(ops[idx][0]) * RW'(ops[idx][1]);
            e.err  = (model_after == 0);
            sb.push_back(e);
            $display("grant: owner=%0d ops={%0d,%0d} exp_data=%0d exp_err=%0d",
                     idx, ops[idx][0], ops[idx][1], e.data, e.err);
        end
        if (single) req[idx] = 1'b0;
        @(negedge gclk);
        check_eq("ack_pulse", {30'd0, req_ack != '0, mul_clr}, 32'd0);
    endtask

    task automatic finish_run(input int exp_en);
        int   n;
        int   n_en;
        exp_t e;
        n    = 0;
        n_en = 0;
        while (rsp_valid == '0 && n < 3000) begin
            if (mul_en) n_en++;
            @(negedge gclk);
            n++;
        end
        if (n >= 3000) begin
            check_eq("rsp_timeout", 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq("en_cycles", 32'(n_en), 32'(exp_en));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
            check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
            check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            check_eq("busy_resp", 32'(busy), 32'd1);
            last_data = e.data;
            $display("resp: owner=%0d data=%0d err=%0d en_cycles=%0d",
                     e.idx, rsp_data, rsp_err, n_en);
        end
    endtask

    task automatic respond(input int idx, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge gclk);
            check_eq("hold_valid", 32'(rsp_valid), 32'(1 << idx));
            check_eq("hold_data", 32'(rsp_data), 32'(last_data));
            check_eq("hold_no_ack", 32'(req_ack), 32'd0);
        end
        rsp_ack = NR'(1 << idx);
        @(negedge gclk);
        rsp_ack = '0;
        check_eq("valid_drop", 32'(rsp_valid), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        rr_model = (idx + 1) % NR;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int idx;
        n_checks    = 0;
        n_fail      = 0;
        rr_model    = 0;
        model_after = 32;
        rst         = 1'b0;
        req         = '0;
        rsp_ack     = '0;
        req_data    = '0;
        last_data   = '0;
        set_ops(0, 3, 5);
        set_ops(1, 7, 9);
        set_ops(2, 31, 31);

        repeat (3) @(negedge gclk);
        check_eq("rst_outs", {req_ack, rsp_valid, 1'b0, rsp_err, mul_clr, mul_en, busy}, 32'd0);
        check_eq("rst_data", 32'(rsp_data), 32'd0);
        check_eq("rst_mdata", {mul_data[1], mul_data[0]}, 32'd0);
        rst = 1'b1;
        @(negedge gclk);

        // Round robin with all three requests held.
        req = 3'b111;
        for (int j = 0; j < 6; j++) begin
            grant(1'b0, idx);
            finish_run(32);
            respond(idx, 1);
        end
        req = '0;
        @(negedge gclk);

        // Single job {3,5}.
        req = 3'b001;
        grant(1'b1, idx);
        finish_run(32);
        respond(idx, 2);

        // Back-pressure with a new request arriving during RESP.
        set_ops(2, 6, 7);
        req = 3'b100;
        grant(1'b1, idx);
        finish_run(32);
        req = 3'b010;
        respond(idx, 10);
        grant(1'b1, idx);
        finish_run(32);
        respond(idx, 1);

        // Timeout, then a normal job.
        model_after = 0;
        req = 3'b001;
        grant(1'b1, idx);
        finish_run(TMO);
        respond(idx, 1);
        model_after = 32;
        set_ops(0, 4, 4);
        req = 3'b001;
        grant(1'b1, idx);
        finish_run(32);
        respond(idx, 1);

        // Done and watchdog on the same cycle; wrong-index ack ignored.
        model_after = TMO;
        set_ops(0, 13, 17);
        req = 3'b001;
        grant(1'b1, idx);
        finish_run(TMO);
        rsp_ack = 3'b100;
        repeat (2) begin
            @(negedge gclk);
            check_eq("wrong_ack", 32'(rsp_valid), 32'd1);
        end
        rsp_ack = '0;
        respond(idx, 0);
        model_after = 32;

        // Reset in RUN cycle 7 with req=100 still pending.
        set_ops(2, 9, 11);
        req = 3'b100;
        grant(1'b0, idx);
        repeat (6) @(negedge gclk);
        check_eq("run7_en", 32'(mul_en), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("async_outs", {req_ack, rsp_valid, 1'b0, rsp_err, mul_clr, mul_en, busy}, 32'd0);
        check_eq("async_mdata", {mul_data[1], mul_data[0]}, 32'd0);
        sb.delete();
        rr_model = 0;
        @(negedge gclk);
        rst = 1'b1;
        grant(1'b1, idx);
        finish_run(32);
        respond(idx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
